rf_wb_arbiter: RTL and testbench

Write-port arbiter and load scoreboard for the single-cycle RV32I integer register file. It shares the file's single write port between three producers:
- ALU/CSR writeback (highest priority, no backpressure)
- returning load data from the LSU (buffered in a small FIFO)
- the debug write port

It optionally tracks registers with outstanding loads and raises a hazard so the decode stage stalls on RAW/WAW dependencies.

---
 rtl/rf_wb_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter
// Shares the single write port of the RV32I integer register file between
// three producers. The producers are ALU/CSR writeback, load data returning
// from the LSU, and the debug write port. ALU writeback has fixed top
// priority. LSU returns wait in a small in-order FIFO. The FIFO head and
// debug writes alternate through a 1-bit round-robin pointer. An optional
// load scoreboard flags RAW/WAW hazards for the decode stage.
//
// Optional feature macro: RF_ARB_SCOREBOARD_EN
//   defined   -> busy vector, hazard and sb_err are active
//   undefined -> hazard = 0, sb_err = 0, ld_issue/ld_issue_rd ignored
//
// Parameter:
//   LSU_FIFO_DEPTH  LSU return buffer entries (power of 2, 2..8)
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   alu_wr_en/rd/data              ALU writeback (rd 0 ignored)
//   lsu_ret_valid/ready/rd/data    load return into the FIFO
//   dbg_wr_valid/ready/rd/data     debug write; ready = granted this cycle
//   ld_issue, ld_issue_rd          load issued (marks rd busy)
//   chk_rs1, chk_rs2, chk_rd       decode operands checked for hazards
//   hazard                         some checked operand has a pending load
//   sb_err                         sticky: ALU wrote a register with a pending load
//   rf_we, rf_waddr, rf_wdata      register file write port
//   lsu_fifo_level                 current FIFO occupancy
module rf_wb_arbiter #(
  parameter int LSU_FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_wr_en,
  input  logic [4:0]  alu_wr_rd,
  input  logic [31:0] alu_wr_data,
  input  logic        lsu_ret_valid,
  output logic        lsu_ret_ready,
  input  logic [4:0]  lsu_ret_rd,
  input  logic [31:0] lsu_ret_data,
  input  logic        dbg_wr_valid,
  output logic        dbg_wr_ready,
  input  logic [4:0]  dbg_wr_rd,
  input  logic [31:0] dbg_wr_data,
  input  logic        ld_issue,
  input  logic [4:0]  ld_issue_rd,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  input  logic [4:0]  chk_rd,
  output logic        hazard,
  output logic        sb_err,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [3:0]  lsu_fifo_level
);

  localparam int PW = $clog2(LSU_FIFO_DEPTH);

  if (LSU_FIFO_DEPTH < 2 || LSU_FIFO_DEPTH > 8 ||
      (LSU_FIFO_DEPTH & (LSU_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("LSU_FIFO_DEPTH must be a power of 2 in 2..8");
  end

  typedef enum logic {
    FAV_LSU = 1'b0,
    FAV_DBG = 1'b1
  } rr_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } lsu_entry_t;

  lsu_entry_t       mem [LSU_FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [3:0]       level;
  rr_e              rr_q;
  rr_e              rr_d;

  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             lsu_wr;     // FIFO head actually written to the RF
  logic             alu_valid;
  lsu_entry_t       head;

  assign full           = (level == 4'(LSU_FIFO_DEPTH));
  assign empty          = (level == 4'd0);
  assign lsu_ret_ready  = !full;
  assign push           = lsu_ret_valid && lsu_ret_ready;
  assign head           = mem[rd_ptr];
  assign alu_valid      = alu_wr_en && (alu_wr_rd != 5'd0);
  assign lsu_fifo_level = level;

  // Grant logic. Everything here is gated off while rst is high so the RF
  // port and the debug handshake stay quiet during reset.
  // NOTE: every output of this block is defaulted first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    rf_we        = 1'b0;
    rf_waddr     = 5'd0;
    rf_wdata     = 32'd0;
    dbg_wr_ready = 1'b0;
    pop          = 1'b0;
    lsu_wr       = 1'b0;
    rr_d         = rr_q;
    if (!rst) begin
      if (alu_valid) begin
        rf_we    = 1'b1;
        rf_waddr = alu_wr_rd;
        rf_wdata = alu_wr_data;
      end else if (!empty && (!dbg_wr_valid || rr_q == FAV_LSU)) begin
        pop = 1'b1;
        // An x0 entry is drained without a write and without a turn change.
        if (head.rd != 5'd0) begin
          rf_we    = 1'b1;
          rf_waddr = head.rd;
          rf_wdata = head.data;
          lsu_wr   = 1'b1;
          rr_d     = FAV_DBG;
        end
      end else if (dbg_wr_valid) begin
        dbg_wr_ready = 1'b1;
        if (dbg_wr_rd != 5'd0) begin
          rf_we    = 1'b1;
          rf_waddr = dbg_wr_rd;
          rf_wdata = dbg_wr_data;
          rr_d     = FAV_LSU;
        end
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= 4'd0;
      rr_q   <= FAV_LSU;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + 4'(push) - 4'(pop);
      rr_q  <= rr_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only read when the
  // level says they are valid, so resetting it would buy nothing.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{rd: lsu_ret_rd, data: lsu_ret_data};
  end

`ifdef RF_ARB_SCOREBOARD_EN
  logic [31:0] busy;
  logic [31:0] busy_d;
  logic        sb_err_q;

  // Clear first, then set, so an issue to the same rd in the cycle its
  // older load retires leaves the register busy.
  always_comb begin
    busy_d = busy;
    if (lsu_wr) busy_d[head.rd] = 1'b0;
    if (ld_issue && ld_issue_rd != 5'd0) busy_d[ld_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 32'd0;
      sb_err_q <= 1'b0;
    end else begin
      busy <= busy_d;
      if (alu_valid && busy[alu_wr_rd]) sb_err_q <= 1'b1;
    end
  end

  assign hazard = busy[chk_rs1] | busy[chk_rs2] | busy[chk_rd];
  assign sb_err = sb_err_q;
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{ld_issue, ld_issue_rd, chk_rs1, chk_rs2, chk_rd};
  assign hazard = 1'b0;
  assign sb_err = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter. A queue-based reference model is
// compared against the DUT on every cycle. Directed literal checks pin the
// model at the interesting points.
module tb_rf_wb_arbiter;

  localparam int DEPTH = 2;
`ifdef RF_ARB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_wr_en = 1'b0;
  logic [4:0]  alu_wr_rd = '0;
  logic [31:0] alu_wr_data = '0;
  logic        lsu_ret_valid = 1'b0;
  logic        lsu_ret_ready;
  logic [4:0]  lsu_ret_rd = '0;
  logic [31:0] lsu_ret_data = '0;
  logic        dbg_wr_valid = 1'b0;
  logic        dbg_wr_ready;
  logic [4:0]  dbg_wr_rd = '0;
  logic [31:0] dbg_wr_data = '0;
  logic        ld_issue = 1'b0;
  logic [4:0]  ld_issue_rd = '0;
  logic [4:0]  chk_rs1 = '0;
  logic [4:0]  chk_rs2 = '0;
  logic [4:0]  chk_rd = '0;
  logic        hazard;
  logic        sb_err;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  lsu_fifo_level;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.LSU_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_wr_en(alu_wr_en), .alu_wr_rd(alu_wr_rd), .alu_wr_data(alu_wr_data),
    .lsu_ret_valid(lsu_ret_valid), .lsu_ret_ready(lsu_ret_ready),
    .lsu_ret_rd(lsu_ret_rd), .lsu_ret_data(lsu_ret_data),
    .dbg_wr_valid(dbg_wr_valid), .dbg_wr_ready(dbg_wr_ready),
    .dbg_wr_rd(dbg_wr_rd), .dbg_wr_data(dbg_wr_data),
    .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
    .hazard(hazard), .sb_err(sb_err),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .lsu_fifo_level(lsu_fifo_level)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t      q[$];
  bit        fav_dbg = 1'b0;
  bit [31:0] m_busy = '0;
  bit        m_err = 1'b0;

  always begin : model
    bit        e_we, e_dready, g_lsu, g_dbg, do_push, m_hz;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    @(negedge clk);
    if (rst) begin
      q.delete();
      fav_dbg = 1'b0;
      m_busy  = '0;
      m_err   = 1'b0;
    end
    e_we = 0; e_dready = 0; g_lsu = 0; g_dbg = 0; e_addr = '0; e_data = '0;
    if (!rst) begin
      if (alu_wr_en && alu_wr_rd != 0) begin
        e_we = 1; e_addr = alu_wr_rd; e_data = alu_wr_data;
      end else if (q.size() > 0 && (!dbg_wr_valid || !fav_dbg)) begin
        g_lsu = 1;
      end else if (dbg_wr_valid) begin
        g_dbg = 1;
      end
    end
    if (g_lsu && q[0].rd != 0) begin
      e_we = 1; e_addr = q[0].rd; e_data = q[0].data;
    end
    if (g_dbg) begin
      e_dready = 1;
      if (dbg_wr_rd != 0) begin
        e_we = 1; e_addr = dbg_wr_rd; e_data = dbg_wr_data;
      end
    end
    m_hz = SB && (m_busy[chk_rs1] || m_busy[chk_rs2] || m_busy[chk_rd]);

    check("rf_we", rf_we, e_we);
    if (e_we) begin
      check("rf_waddr", rf_waddr, e_addr);
      check("rf_wdata", rf_wdata, e_data);
    end
    check("dbg_wr_ready", dbg_wr_ready, e_dready);
    check("lsu_ret_ready", lsu_ret_ready, q.size() < DEPTH);
    check("lsu_fifo_level", lsu_fifo_level, q.size());
    check("hazard", hazard, m_hz);
    check("sb_err", sb_err, SB && m_err);

    @(posedge clk);
    if (!rst) begin
      do_push = lsu_ret_valid && q.size() < DEPTH;
      if (SB) begin
        if (alu_wr_en && alu_wr_rd != 0 && m_busy[alu_wr_rd]) m_err = 1;
        if (g_lsu && q[0].rd != 0) m_busy[q[0].rd] = 0;
        if (ld_issue && ld_issue_rd != 0) m_busy[ld_issue_rd] = 1;
      end
      if (g_lsu) begin
        if (q[0].rd != 0) fav_dbg = 1;
        void'(q.pop_front());
      end
      if (g_dbg && dbg_wr_rd != 0) fav_dbg = 0;
      if (do_push) q.push_back('{rd: lsu_ret_rd, data: lsu_ret_data});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_wr_en = 0; alu_wr_rd = '0; alu_wr_data = '0;
    lsu_ret_valid = 0; lsu_ret_rd = '0; lsu_ret_data = '0;
    dbg_wr_valid = 0; dbg_wr_rd = '0; dbg_wr_data = '0;
    ld_issue = 0; ld_issue_rd = '0;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
    lsu_ret_valid = 1; lsu_ret_rd = rd; lsu_ret_data = d;
  endtask

  task automatic dbg(input logic [4:0] rd, input logic [31:0] d);
    dbg_wr_valid = 1; dbg_wr_rd = rd; dbg_wr_data = d;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    alu_wr_en = 1; alu_wr_rd = rd; alu_wr_data = d;
  endtask

  // Fill the FIFO with two entries behind a continuous ALU stream while
  // debug is also requesting.
  task automatic fill_blocked();
    alu(5'd5, 32'hDEADBEEF); dbg(5'd12, 32'hC0); lsu(5'd10, 32'hA0);
    tick();
    lsu(5'd11, 32'hB0);
    tick();
    lsu_ret_valid = 0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    idle();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_rf_we", rf_we, 0);
    check("rst_level", lsu_fifo_level, 0);
    check("rst_ready", lsu_ret_ready, 1);
    check("rst_dbg_ready", dbg_wr_ready, 0);
    tick();
    rst = 0;
    tick();

    // ALU priority with a full FIFO and debug pending.
    fill_blocked();
    repeat (2) begin
      @(negedge clk);
      check("alu_waddr", rf_waddr, 5);
      check("alu_wdata", rf_wdata, 32'hDEADBEEF);
      check("alu_full_ready", lsu_ret_ready, 0);
      check("alu_dbg_ready", dbg_wr_ready, 0);
      tick();
    end

    // Reset mid-operation discards the FIFO.
    rst = 1;
    @(negedge clk);
    check("midrst_rf_we", rf_we, 0);
    check("midrst_level", lsu_fifo_level, 0);
    check("midrst_ready", lsu_ret_ready, 1);
    check("midrst_hazard", hazard, 0);
    tick();
    rst = 0; idle();
    @(negedge clk);
    check("postrst_level", lsu_fifo_level, 0);
    check("postrst_rf_we", rf_we, 0);
    tick();

    // Refill, then drop the ALU: LSU, debug, LSU, debug.
    fill_blocked();
    alu_wr_en = 0;
    @(negedge clk);
    check("rr1_waddr", rf_waddr, 10);
    check("rr1_wdata", rf_wdata, 32'hA0);
    check("rr1_dbg_ready", dbg_wr_ready, 0);
    tick();
    @(negedge clk);
    check("rr2_waddr", rf_waddr, 12);
    check("rr2_dbg_ready", dbg_wr_ready, 1);
    tick();
    dbg(5'd13, 32'hD0);
    @(negedge clk);
    check("rr3_waddr", rf_waddr, 11);
    check("rr3_wdata", rf_wdata, 32'hB0);
    tick();
    @(negedge clk);
    check("rr4_waddr", rf_waddr, 13);
    tick();
    idle();

    // LSU ordering, no bypass; an ALU request to x0 is ignored.
    lsu(5'd3, 32'h11);
    @(negedge clk);
    check("nobypass_rf_we", rf_we, 0);
    tick();
    lsu(5'd4, 32'h22);
    @(negedge clk);
    check("ord1_waddr", rf_waddr, 3);
    check("ord1_wdata", rf_wdata, 32'h11);
    tick();
    lsu_ret_valid = 0; alu(5'd0, 32'h12345678);
    @(negedge clk);
    check("ord2_waddr", rf_waddr, 4);
    check("ord2_wdata", rf_wdata, 32'h22);
    tick();
    idle();

    // x0 discards; pointer currently favours debug and must stay that way.
    dbg(5'd0, 32'hFFFFFFFF); lsu(5'd0, 32'h55);
    @(negedge clk);
    check("x0dbg_ready", dbg_wr_ready, 1);
    check("x0dbg_rf_we", rf_we, 0);
    tick();
    dbg(5'd14, 32'hE0); lsu(5'd15, 32'hF0);
    @(negedge clk);
    check("x0ptr_waddr", rf_waddr, 14);
    tick();
    idle();
    @(negedge clk);
    check("x0lsu_rf_we", rf_we, 0);
    check("x0lsu_level", lsu_fifo_level, 2);
    tick();
    dbg(5'd16, 32'h16);
    @(negedge clk);
    check("x0lsu_ptr_waddr", rf_waddr, 15);
    check("x0lsu_ptr_dready", dbg_wr_ready, 0);
    tick();
    @(negedge clk);
    check("x0lsu_dbg_waddr", rf_waddr, 16);
    tick();
    idle();

    // Scoreboard set/clear.
    chk_rs1 = 5'd7;
    ld_issue = 1; ld_issue_rd = 5'd7;
    @(negedge clk);
    check("sb_set_hz0", hazard, 0);
    tick();
    ld_issue = 0; lsu(5'd7, 32'h77);
    @(negedge clk);
    check("sb_set_hz1", hazard, SB);
    tick();
    lsu_ret_valid = 0;
    @(negedge clk);
    check("sb_clr_wr", rf_waddr, 7);
    check("sb_clr_hz_still", hazard, SB);
    tick();
    @(negedge clk);
    check("sb_clr_hz0", hazard, 0);
    tick();

    // Set and clear on the same rd in the same cycle: set wins.
    ld_issue = 1; ld_issue_rd = 5'd7;
    tick();
    ld_issue = 0; lsu(5'd7, 32'h78);
    tick();
    lsu_ret_valid = 0; ld_issue = 1; ld_issue_rd = 5'd7;
    @(negedge clk);
    check("sb_same_wr", rf_waddr, 7);
    tick();
    ld_issue = 0; chk_rs1 = 5'd1; chk_rd = 5'd7; lsu(5'd7, 32'h79);
    @(negedge clk);
    check("sb_same_hz", hazard, SB);
    tick();
    lsu_ret_valid = 0;
    tick();
    @(negedge clk);
    check("sb_same_clr", hazard, 0);
    chk_rd = 5'd0;
    tick();

    // sb_err: ALU writes a register with a pending load.
    ld_issue = 1; ld_issue_rd = 5'd9; chk_rs2 = 5'd9;
    tick();
    ld_issue = 0; alu(5'd9, 32'h99);
    @(negedge clk);
    check("sberr_pre", sb_err, 0);
    check("sberr_hz_rs2", hazard, SB);
    tick();
    idle();
    repeat (3) begin
      @(negedge clk);
      check("sberr_sticky", sb_err, SB);
      tick();
    end
    rst = 1;
    @(negedge clk);
    check("sberr_rst", sb_err, 0);
    check("sberr_rst_hz", hazard, 0);
    tick();
    rst = 0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
